// File: rtl/fir_pkg.sv
// Shared defaults and types for the FIR decimate/requantize stage.
package fir_pkg;

  localparam int unsigned FIR_IN_W   = 30;
  localparam int unsigned FIR_OUT_W  = 16;
  localparam int unsigned FIR_SHIFT  = 13;
  localparam int unsigned FIR_DECIM  = 4;
  localparam int unsigned FIR_DROP_W = 16;

  typedef logic [FIR_DROP_W-1:0] drop_cnt_t;

  // Phase counter width; a DECIM of 1 still needs a 1-bit register.
  function automatic int unsigned phase_w(input int unsigned decim);
    return (decim > 1) ? $clog2(decim) : 1;
  endfunction

endpackage

// File: rtl/fir_decim_requant_if.sv
// Bus between the requantizer and its producer/consumer: enable, sample in, handshake out, status.
interface fir_decim_requant_if
  import fir_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = FIR_IN_W,
  parameter int unsigned OUT_WIDTH = FIR_OUT_W
);

  logic                        en;
  logic signed [IN_WIDTH-1:0]  din;
  logic signed [OUT_WIDTH-1:0] dout;
  logic                        dout_vld;
  logic                        dout_rdy;
  logic                        ovf;
  logic                        ovf_clr;
  drop_cnt_t                   drop_cnt;

  modport master (
    output en, din, dout_rdy, ovf_clr,
    input  dout, dout_vld, ovf, drop_cnt
  );

  modport slave (
    input  en, din, dout_rdy, ovf_clr,
    output dout, dout_vld, ovf, drop_cnt
  );

endinterface

// File: rtl/fir_out_fifo2.sv
// Two-entry synchronous FIFO; push and pop in the same cycle are both honoured even when full.
module fir_out_fifo2
  import fir_pkg::*;
#(
  parameter int unsigned Width = FIR_OUT_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [Width-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  // When full, a pop frees the head slot, which is exactly where the write pointer sits.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fir_decim_requant.sv
// Decimate, round-half-up, shift and narrow the FIR output into a 2-entry handshake buffer.
// Define FIR_REQ_SAT_EN to saturate instead of wrapping when narrowing.
module fir_decim_requant
  import fir_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = FIR_IN_W,
  parameter int unsigned OUT_WIDTH = FIR_OUT_W,
  parameter int unsigned SHIFT     = FIR_SHIFT,
  parameter int unsigned DECIM     = FIR_DECIM
) (
  input logic                clk,
  input logic                n_rst,
  fir_decim_requant_if.slave bus
);

  localparam int unsigned PhW = phase_w(DECIM);
  localparam logic [PhW-1:0] PhLast = PhW'(DECIM - 1);
  localparam logic signed [IN_WIDTH:0] RndOfs = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_WIDTH:0] SatMax =
    {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] SatMin =
    {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic [PhW-1:0]              r_phase;
  logic signed [IN_WIDTH:0]    r1;
  logic                        r1_vld;
  logic [OUT_WIDTH-1:0]        r2;
  logic                        r2_vld;
  logic                        r_ovf;
  drop_cnt_t                   r_drop;

  logic                        w_cap;
  logic signed [IN_WIDTH:0]    w_shift;
  logic [OUT_WIDTH-1:0]        w_q;
  logic [OUT_WIDTH-1:0]        w_head;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_pop;
  logic                        w_drop;

  assign w_cap   = bus.en && (r_phase == PhLast);
  assign w_shift = r1 >>> SHIFT;
  assign w_pop   = !w_empty && bus.dout_rdy;
  // The pipeline never stalls, so an arrival that finds no room is lost.
  assign w_drop  = r2_vld && w_full && !w_pop;

  always_comb begin
    w_q = OUT_WIDTH'(w_shift);
`ifdef FIR_REQ_SAT_EN
    if (w_shift > SatMax) begin
      w_q = OUT_WIDTH'(SatMax);
    end else if (w_shift < SatMin) begin
      w_q = OUT_WIDTH'(SatMin);
    end
`else
    w_q = OUT_WIDTH'(w_shift);
`endif
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_phase <= '0;
      r1      <= '0;
      r1_vld  <= 1'b0;
      r2      <= '0;
      r2_vld  <= 1'b0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      if (!bus.en || (r_phase == PhLast)) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
      r1_vld <= w_cap;
      if (w_cap) begin
        r1 <= $signed({bus.din[IN_WIDTH-1], bus.din}) + RndOfs;
      end
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2 <= w_q;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_drop && (r_drop != '1)) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  fir_out_fifo2 #(
    .Width(OUT_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_push (r2_vld),
    .i_data (r2),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign bus.dout     = $signed(w_head);
  assign bus.dout_vld = !w_empty;
  assign bus.ovf      = r_ovf;
  assign bus.drop_cnt = r_drop;

endmodule

// File: tb/tb_fir_decim_requant.sv
// Randomized scoreboard bench for fir_decim_requant against an arithmetic reference model.
module tb_fir_decim_requant;
  import fir_pkg::*;

  localparam int unsigned IW = 30;
  localparam int unsigned OW = 16;
  localparam int unsigned SH = 13;
  localparam int unsigned DC = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  fir_decim_requant_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  fir_decim_requant #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .SHIFT    (SH),
    .DECIM    (DC)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // floor((d + 2^(SH-1)) / 2^SH), then narrowed to OW bits.
  function automatic longint requant(input longint d);
    longint v;
    longint q;
    longint lim;
    v   = d + (longint'(1) << (SH - 1));
    q   = (v >= 0) ? v / (longint'(1) << SH)
                   : -((-v + (longint'(1) << SH) - 1) / (longint'(1) << SH));
    lim = longint'(1) << (OW - 1);
`ifdef FIR_REQ_SAT_EN
    if (q > lim - 1) q = lim - 1;
    if (q < -lim) q = -lim;
`else
    q = q & (2 * lim - 1);
    if (q >= lim) q = q - 2 * lim;
`endif
    return q;
  endfunction

  typedef struct {
    longint val;
    longint due;
  } pend_t;

  pend_t  pend[$];
  longint exp_q[$];
  int     m_phase = 0;
  bit     m_ovf = 1'b0;
  int     m_drop = 0;
  longint edge_n = 0;

  bit     s_rst = 1'b0;
  bit     s_en = 1'b0;
  bit     s_clr = 1'b0;
  longint s_din = 0;

  // Inputs are frozen mid-cycle and applied to the model at the following edge.
  always @(negedge clk) begin
    s_rst = n_rst;
    s_en  = bus.en;
    s_clr = bus.ovf_clr;
    s_din = longint'(bus.din);
  end

  always @(posedge clk) begin : model
    bit    drop;
    pend_t p;
    edge_n++;
    if (!s_rst) begin
      pend.delete();
      exp_q.delete();
      m_phase = 0;
      m_ovf   = 1'b0;
      m_drop  = 0;
    end else begin
      drop = 1'b0;
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        p = pend.pop_front();
        if (exp_q.size() < 2) exp_q.push_back(p.val);
        else drop = 1'b1;
      end
      if (drop) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end else if (s_clr) begin
        m_ovf = 1'b0;
      end
      if (s_en && m_phase == DC - 1) pend.push_back('{val: requant(s_din), due: edge_n + 2});
      m_phase = s_en ? (m_phase + 1) % DC : 0;
    end
  end

  // Monitor: the monitor's pop stands for the consumer taking the head before the edge.
  always @(negedge clk) begin
    if (mon_on) begin
      check("dout_vld", longint'(bus.dout_vld), longint'(exp_q.size() > 0));
      check("ovf", longint'(bus.ovf), longint'(m_ovf));
      check("drop_cnt", longint'(bus.drop_cnt), longint'(m_drop));
      if (bus.dout_vld && bus.dout_rdy && exp_q.size() > 0) begin
        check("dout", longint'(bus.dout), exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int dir_vals[5] = '{16384, -12288, -4097, 536870911, -536870912};

  initial begin
    bus.en       = 1'b0;
    bus.din      = '0;
    bus.dout_rdy = 1'b0;
    bus.ovf_clr  = 1'b0;
    n_rst        = 1'b0;
    cycles(3);
    n_rst  = 1'b1;
    mon_on = 1'b1;
    check("rst_dout", longint'(bus.dout), 0);
    check("rst_vld", longint'(bus.dout_vld), 0);

    bus.en       = 1'b1;
    bus.dout_rdy = 1'b1;
    bus.din      = IW'(20480);
    cycles(24);

    foreach (dir_vals[i]) begin
      bus.din = IW'(dir_vals[i]);
      cycles(2 * DC);
    end

    for (int i = 0; i < 600; i++) begin
      bus.en       = ($urandom % 8) != 0;
      bus.din      = ($urandom % 2) != 0 ? IW'($urandom)
                                         : IW'(int'($urandom_range(0, 200000)) - 100000);
      bus.dout_rdy = (i < 300) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      bus.ovf_clr  = ($urandom % 16) == 0;
      cycles(1);
    end

    bus.ovf_clr  = 1'b0;
    bus.en       = 1'b1;
    bus.dout_rdy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.din = IW'(i * 8192);
      cycles(1);
    end
    check("full_before_rst", longint'(exp_q.size()), 2);
    n_rst = 1'b0;
    cycles(1);
    n_rst = 1'b1;
    check("rst2_dout", longint'(bus.dout), 0);
    check("rst2_vld", longint'(bus.dout_vld), 0);
    check("rst2_ovf", longint'(bus.ovf), 0);
    check("rst2_drop", longint'(bus.drop_cnt), 0);

    // Stalled consumer from a clean start, then drain in order.
    for (int i = 0; i < 20; i++) begin
      bus.din = IW'(i * 8192);
      cycles(1);
    end
    bus.dout_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.din = IW'(-i * 8192);
      cycles(1);
    end

    bus.en = 1'b0;
    cycles(10);
    check("drain_empty", longint'(exp_q.size()), 0);
    check("drain_pend", longint'(pend.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_decim_requant.md
# fir_decim_requant

Downstream stage of the 16-tap FIR filter: takes the filter's full-precision signed output every clock, decimates by a fixed ratio, and requantizes it to a narrower signed word with round-half-up and saturation. Results go to the consumer through a valid/ready handshake with a 2-entry output buffer. Buffer overruns are counted and flagged, never stalled, because the FIR runs free.

## Interface
- IN_WIDTH, 30, width of signed FIR output (WIDTH+16 for WIDTH=14)
- OUT_WIDTH, 16, width of signed requantized output
- SHIFT, 13, right-shift applied after rounding (1 ≤ SHIFT < IN_WIDTH)
- DECIM, 4, decimation ratio (≥ 1; 1 = no decimation)

- clk  in  1  system clock, rising edge
- n_rst  in  1  reset, synchronous, active-low
- en  in  1  decimation enable; low holds phase counter at 0, no captures
- din  in  IN_WIDTH  signed FIR output, sampled every clock
- dout  out  OUT_WIDTH  signed requantized sample, head of output buffer
- dout_vld  out  1  dout holds a valid sample
- dout_rdy  in  1  consumer accepts dout when dout_vld && dout_rdy
- ovf  out  1  sticky: a sample was dropped because the buffer was full
- ovf_clr  in  1  clears ovf
- drop_cnt  out  16  count of dropped samples, saturates at 65535; cleared only by reset

## Operation
- Phase counter counts 0..DECIM-1 while en=1, wraps to 0. When en=0 it is held at 0.
- Capture: din is taken when en=1 and phase==DECIM-1. Samples already in the pipeline always complete, regardless of en.
- Stage 1 (capture register): r1 = sext(din, IN_WIDTH+1) + 2^(SHIFT-1). The extra bit prevents rounding overflow.
- Stage 2: s = r1 >>> SHIFT (arithmetic). The result is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], or wrapped (see Configuration).
- Stage 3: push into the 2-entry FIFO.
  - Pop when dout_vld && dout_rdy.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full. No drop occurs in that case.
  - Push when full with no pop: the sample is discarded, ovf←1, drop_cnt increments (saturating).
  - ovf_clr with a simultaneous drop: set wins, ovf stays 1.
- Stage valid bits track stages 1–2. A bubble never pushes.
- dout always shows the FIFO head. dout is stable while dout_vld=1 and dout_rdy=0.

## Timing
- Reset values (n_rst=0 at a rising edge): phase=0, stage valids=0, FIFO empty, dout=0, dout_vld=0, ovf=0, drop_cnt=0.
- Reset mid-operation discards all in-flight and buffered samples. There is no partial output.
- Latency: capture at edge E0. The stage 2 register loads at E1. The FIFO write happens at E2. dout_vld=1 in the cycle after E2, i.e. 3 edges from capture, with an empty buffer.
- Throughput: one output per DECIM cycles. With DECIM=1 and dout_rdy tied high, there is sustained 1 sample/clk with no drops.
- The pipeline never stalls. Backpressure is absorbed only by the 2-entry FIFO, after which samples are dropped.
- A change of en takes effect on the next edge. en falling on the capture cycle still captures that sample.

## Configuration
- FIR_REQ_SAT_EN defined: stage 2 saturates to the OUT_WIDTH range.
- FIR_REQ_SAT_EN undefined: stage 2 keeps the low OUT_WIDTH bits (two's-complement wrap). All other behaviour is identical.

## Structure
- Shared package fir_pkg holds:
  - default widths FIR_IN_W=30, FIR_OUT_W=16
  - FIR_SHIFT=13
  - FIR_DECIM=4
  - typedef for the drop counter width (16)
- One sub-module: fir_out_fifo2. It is a 2-entry synchronous FIFO with push/pop/full/empty, sync active-low reset, and simultaneous push+pop when full.
- Top-level holds the phase counter, round/shift/clamp pipeline, ovf and drop_cnt.

## Test plan
- Defaults, en=1, dout_rdy=1, din constant 20480 → dout=3 every 4th cycle. First dout_vld 3 edges after the first capture edge.
- din=16384 → 2; din=-12288 → -1; din=-4097 → -1 (round-half-up on negatives).
- din=536870911:
  - with FIR_REQ_SAT_EN → 32767
  - without → 0
  - din=-536870912 with saturation → -32768
- dout_rdy=0 for 20 cycles, DECIM=4 → 2 samples buffered and stable, the rest dropped. ovf=1, drop_cnt=3 (captures 3–5). Raising dout_rdy drains the 2 oldest samples in order.
- DECIM=1, FIFO full, dout_rdy=1 on the push cycle → no drop, drop_cnt unchanged. ovf_clr asserted on a drop cycle → ovf stays 1.
- n_rst=0 for one edge with the FIFO holding 2 samples → next cycle: dout_vld=0, dout=0, ovf=0, drop_cnt=0, phase restarts at 0.
